sha256_round_ctrl: RTL and testbench
====================================

# sha256_round_ctrl

Round sequencer and message-schedule engine for the SHA-256 datapath. Accepts the sixteen 32-bit big-endian words of one padded 512-bit block from the padder/parser word stream and stores them in a 16-entry circular W buffer. It then drives the compression core through rounds 0..63, supplying W[t] and K[t] each round. It emits init, final and done strobes that frame the block.

## Interface
- No parameters. Block size (16 words) and round count (64) are fixed constants.
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-low reset.
- i_start  in  1  begin a block; sampled only in IDLE.
- i_word_valid  in  1  i_word carries a padded message word.
- i_word  in  32  padded word, first word = bytes 0..3, MSB = byte 0.
- o_word_ready  out  1  word accepted on cycles where i_word_valid && o_word_ready.
- i_hold  in  1  compression-core stall; freezes round sequencing.
- o_init  out  1  one-cycle pulse: core loads working vars a..h from H.
- o_round_en  out  1  o_round_idx/o_wt/o_kt valid; core executes one round.
- o_round_idx  out  6  current round t.
- o_wt  out  32  W[t].
- o_kt  out  32  K[t].
- o_final  out  1  one-cycle pulse: core adds a..h into H.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse: block complete.

## Operation
- States: IDLE, LOAD, INIT, ROUNDS, FINAL, DONE.
- IDLE → LOAD when i_start=1. Otherwise hold.
- LOAD:
  - o_word_ready=1.
  - Each accepted word is written to buf[cnt] and cnt increments.
  - The cycle that accepts word 15 transitions to INIT.
  - i_word_valid=0 simply waits.
- INIT: o_init=1 for exactly one cycle, then go to ROUNDS with t=0.
- ROUNDS:
  - o_round_en = ~i_hold.
  - t<16: o_wt = buf[t].
  - t≥16: o_wt = σ1(buf[(t-2)%16]) + buf[(t-7)%16] + σ0(buf[(t-15)%16]) + buf[t%16], mod 2^32. On each o_round_en cycle this value is written to buf[t%16].
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - o_kt = K[t].
  - t increments on each o_round_en cycle. After round 63 the state moves to FINAL and t wraps to 0.
- FINAL: o_final=1 for one cycle, then go to DONE.
- DONE: o_done=1 for one cycle, then return to IDLE.
- Ignored inputs:
  - i_start outside IDLE is ignored.
  - i_word_valid outside LOAD is ignored (o_word_ready=0).
  - i_hold outside ROUNDS is ignored.
- Reset values: state=IDLE, cnt=0, t=0. All outputs are 0: o_word_ready, o_init, o_round_en, o_round_idx, o_wt, o_kt, o_final, o_busy, o_done. The buf contents are don't-care.
- Reset mid-operation (any state): return to IDLE on the next edge. Strobes drop immediately and no o_done is issued.

## Timing
- All state, counters and buf are registered. o_round_en/o_wt/o_kt/o_round_idx are combinational from registered state, t and buf, plus i_hold.
- i_start at edge N → o_word_ready=1 from cycle N+1.
- Word 15 accepted at edge M:
  - o_init is high in cycle M+1.
  - Round 0 is in cycle M+2.
  - Round 63 is in cycle M+65 (no holds).
  - o_final is in cycle M+66.
  - o_done is in cycle M+67.
- Each hold cycle adds exactly one cycle. i_hold=1 during round t keeps o_round_idx=t, keeps o_wt stable, and leaves buf unwritten.
- Back-to-back: i_start can be asserted in the cycle after o_done. LOAD is re-entered with cnt=0.

## Structure
- Package sha256_pkg (shared with the compression core and the future multi-block controller):
  - K[0:63] constant array.
  - H0 IV constants.
  - σ0/σ1/Σ0/Σ1/Ch/Maj functions.
  - State enum.
  - Constants BLK_WORDS=16, ROUNDS=64.
- Sub-module sha256_w_expand: purely combinational. Takes four buf taps and returns the new W word. It is reused by the core's unrolled variant.

## Test plan
- "abc" block (0x61626380, 14×0x00000000, 0x00000018) with no holds → o_wt sequence:
  - t=0: 0x61626380.
  - t=15: 0x00000018.
  - t=16: 0x61626380.
  - t=17: 0x000F0000.
  - t=18: 0x7DA86405.
  - t=63: 0x12B1EDEB.
  - Also check o_kt: t=0 gives 0x428A2F98, t=63 gives 0xC67178F2.
  - o_done arrives exactly 67 cycles after the word-15 accept.
- Gapped words: i_word_valid toggles every other cycle → 16 words are stored in order, and o_init appears only after the 16th word.
- Holds: i_hold=1 for 3 cycles at t=20 and 1 cycle at t=63 → o_round_idx is frozen, o_wt is unchanged, o_done is delayed by exactly 4 cycles, and the W stream is identical to the no-hold run.
- Spurious inputs: i_start and i_word_valid asserted during ROUNDS → no state change, no buf corruption, o_word_ready=0.
- Reset mid-flight: i_rst=0 at t=30 → next cycle state=IDLE and all outputs are 0. A new "abc" block then produces the correct stream.
- Back-to-back: i_start in the cycle after o_done, repeated twice → both blocks produce identical W/K streams.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, helper functions and sequencer state encoding.
// Used by the round controller, the compression core and the multi-block controller.
package sha256_pkg;

    localparam int BLK_WORDS = 16;
    localparam int ROUNDS    = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_INIT,
        ST_ROUNDS,
        ST_FINAL,
        ST_DONE
    } state_t;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] H0 [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] big_sig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_w_expand.sv
// Combinational message-schedule step: W[t] from the four earlier schedule taps.
// Shared with the unrolled compression core.
module sha256_w_expand
    import sha256_pkg::*;
(
    input  logic [31:0] w_m2,
    input  logic [31:0] w_m7,
    input  logic [31:0] w_m15,
    input  logic [31:0] w_m16,
    output logic [31:0] w_new
);

    assign w_new = sig1(w_m2) + w_m7 + sig0(w_m15) + w_m16;

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 round sequencer: loads one 16-word block into a circular W buffer,
// then streams W[t]/K[t] for rounds 0..63 with init/final/done framing strobes.
module sha256_round_ctrl
    import sha256_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_word_valid,
    input  logic [31:0] i_word,
    output logic        o_word_ready,
    input  logic        i_hold,
    output logic        o_init,
    output logic        o_round_en,
    output logic [5:0]  o_round_idx,
    output logic [31:0] o_wt,
    output logic [31:0] o_kt,
    output logic        o_final,
    output logic        o_busy,
    output logic        o_done
);

    localparam logic [3:0] LAST_WORD  = 4'(BLK_WORDS - 1);
    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [5:0]  t;
    logic [31:0] wbuf [0:BLK_WORDS-1];
    logic        word_ready;
    logic        round_en;
    logic        accept;
    logic        in_rounds;
    logic [3:0]  t_lo;
    logic [31:0] w_new;
    logic [31:0] wt;

    always_ff @(posedge i_clk) begin
        if (!i_rst) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Active-low reset also masks the strobes combinationally so they drop in the reset cycle.
    always_comb begin
        state_nxt  = state;
        word_ready = 1'b0;
        round_en   = 1'b0;
        o_init     = 1'b0;
        o_final    = 1'b0;
        o_done     = 1'b0;
        o_busy     = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (i_start) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                word_ready = 1'b1;
                if (i_word_valid && (cnt == LAST_WORD)) state_nxt = ST_INIT;
            end
            ST_INIT: begin
                o_init    = 1'b1;
                state_nxt = ST_ROUNDS;
            end
            ST_ROUNDS: begin
                round_en = ~i_hold;
                if (!i_hold && (t == LAST_ROUND)) state_nxt = ST_FINAL;
            end
            ST_FINAL: begin
                o_final   = 1'b1;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                o_done    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (!i_rst) begin
            word_ready = 1'b0;
            round_en   = 1'b0;
            o_init     = 1'b0;
            o_final    = 1'b0;
            o_done     = 1'b0;
            o_busy     = 1'b0;
        end
    end

    assign accept = word_ready & i_word_valid;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            cnt <= '0;
            t   <= '0;
        end else begin
            if (state == ST_IDLE) cnt <= '0;
            else if (accept)      cnt <= cnt + 4'd1;
            if (round_en)         t   <= t + 6'd1;
        end
    end

    // W buffer holds the last 16 schedule words; slot t%16 holds W[t-16] until overwritten by W[t].
    always_ff @(posedge i_clk) begin
        if (accept)   wbuf[cnt]  <= i_word;
        if (round_en) wbuf[t_lo] <= wt;
    end

    assign t_lo = t[3:0];

    sha256_w_expand u_w_expand (
        .w_m2  (wbuf[t_lo - 4'd2]),
        .w_m7  (wbuf[t_lo - 4'd7]),
        .w_m15 (wbuf[t_lo - 4'd15]),
        .w_m16 (wbuf[t_lo]),
        .w_new (w_new)
    );

    assign wt = (t[5:4] == 2'b00) ? wbuf[t_lo] : w_new;

    assign in_rounds    = i_rst && (state == ST_ROUNDS);
    assign o_word_ready = word_ready;
    assign o_round_en   = round_en;
    assign o_round_idx  = in_rounds ? t    : '0;
    assign o_wt         = in_rounds ? wt   : '0;
    assign o_kt         = in_rounds ? K[t] : '0;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench for sha256_round_ctrl: "abc" block, gapped load, holds,
// spurious inputs, mid-flight reset and back-to-back blocks against a local schedule model.
module tb_sha256_round_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_start = 1'b0;
    logic        i_word_valid = 1'b0;
    logic [31:0] i_word = '0;
    logic        i_hold = 1'b0;
    logic        o_word_ready;
    logic        o_init;
    logic        o_round_en;
    logic [5:0]  o_round_idx;
    logic [31:0] o_wt;
    logic [31:0] o_kt;
    logic        o_final;
    logic        o_busy;
    logic        o_done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int accept_cyc = 0;

    logic [31:0] blk   [0:15];
    logic [31:0] exp_w [0:63];

    sha256_round_ctrl dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_word_valid (i_word_valid),
        .i_word       (i_word),
        .o_word_ready (o_word_ready),
        .i_hold       (i_hold),
        .o_init       (o_init),
        .o_round_en   (o_round_en),
        .o_round_idx  (o_round_idx),
        .o_wt         (o_wt),
        .o_kt         (o_kt),
        .o_final      (o_final),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [31:0] m_sg0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] m_sg1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    task automatic build_model;
        for (int i = 0; i < 16; i++) exp_w[i] = blk[i];
        for (int i = 16; i < 64; i++)
            exp_w[i] = m_sg1(exp_w[i-2]) + exp_w[i-7] + m_sg0(exp_w[i-15]) + exp_w[i-16];
    endtask

    task automatic set_abc;
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
        build_model();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"}, {26'b0, o_word_ready, o_init, o_round_en, o_final, o_busy, o_done}, 32'h0);
        check({tag, "_idx"}, {26'b0, o_round_idx}, 32'h0);
        check({tag, "_wt"}, o_wt, 32'h0);
        check({tag, "_kt"}, o_kt, 32'h0);
    endtask

    task automatic load_block(input bit gapped);
        tick();
        i_start = 1'b1;
        #1;
        check("idle_busy", o_busy, 1'b0);
        check("idle_ready", o_word_ready, 1'b0);
        tick();
        i_start = 1'b0;
        #1;
        check("load_ready", o_word_ready, 1'b1);
        check("load_busy", o_busy, 1'b1);
        for (int i = 0; i < 16; i++) begin
            if (gapped) begin
                i_word_valid = 1'b0;
                i_word = 32'hdeadbeef;
                tick();
                check("gap_no_init", o_init, 1'b0);
            end
            i_word_valid = 1'b1;
            i_word = blk[i];
            tick();
            if (i < 15) check("early_init", o_init, 1'b0);
        end
        i_word_valid = 1'b0;
        accept_cyc = cyc;
        #1;
        check("init_pulse", o_init, 1'b1);
        check("init_ready", o_word_ready, 1'b0);
    endtask

    task automatic run_rounds(input bit hold_mode, input bit spurious, input bit abc, input int abort_at);
        int exp_t = 0;
        int h20 = 0;
        int h63 = 0;
        int budget = 0;
        bit hold;
        tick();
        while (exp_t < 64 && budget < 200) begin
            budget++;
            hold = hold_mode && ((exp_t == 20 && h20 < 3) || (exp_t == 63 && h63 < 1));
            i_hold = hold;
            if (spurious) begin
                i_start = 1'b1;
                i_word_valid = 1'b1;
                i_word = $urandom;
            end
            if (exp_t == abort_at) begin
                i_rst = 1'b0;
                i_hold = 1'b0;
                #1;
                check("rst_strobe_drop", o_round_en, 1'b0);
                tick();
                i_rst = 1'b1;
                #1;
                check_all_zero("after_rst");
                return;
            end
            #1;
            check("round_idx", {26'b0, o_round_idx}, exp_t);
            check("round_wt", o_wt, exp_w[exp_t]);
            check("round_en", o_round_en, !hold);
            if (spurious) check("spur_ready", o_word_ready, 1'b0);
            if (exp_t == 0)  check("kt_0", o_kt, 32'h428a2f98);
            if (exp_t == 20) check("kt_20", o_kt, 32'h2de92c6f);
            if (exp_t == 63) check("kt_63", o_kt, 32'hc67178f2);
            if (abc) begin
                case (exp_t)
                    0:  check("abc_w0",  o_wt, 32'h61626380);
                    15: check("abc_w15", o_wt, 32'h00000018);
                    16: check("abc_w16", o_wt, 32'h61626380);
                    17: check("abc_w17", o_wt, 32'h000f0000);
                    18: check("abc_w18", o_wt, 32'h7da86405);
                    63: check("abc_w63", o_wt, 32'h12b1edeb);
                    default: ;
                endcase
            end
            if (hold) begin
                if (exp_t == 20) h20++;
                else h63++;
            end else begin
                exp_t++;
            end
            tick();
        end
        i_hold = 1'b0;
        i_start = 1'b0;
        i_word_valid = 1'b0;
        if (budget >= 200) check("rounds_timeout", exp_t, 64);
        #1;
        check("final_pulse", o_final, 1'b1);
        check("final_no_done", o_done, 1'b0);
        tick();
        check("done_pulse", o_done, 1'b1);
        check("done_final_low", o_final, 1'b0);
        check("done_latency", cyc - accept_cyc, hold_mode ? 70 : 66);
    endtask

    initial begin
        repeat (3) tick();
        check_all_zero("in_rst");
        i_rst = 1'b1;
        #1;
        check_all_zero("post_rst");

        set_abc();
        load_block(1'b0);
        run_rounds(1'b0, 1'b0, 1'b1, -1);
        load_block(1'b0);
        run_rounds(1'b0, 1'b0, 1'b1, -1);
        load_block(1'b0);
        run_rounds(1'b0, 1'b0, 1'b1, -1);

        load_block(1'b0);
        run_rounds(1'b1, 1'b0, 1'b1, -1);

        load_block(1'b0);
        run_rounds(1'b0, 1'b1, 1'b1, -1);

        for (int i = 0; i < 16; i++) blk[i] = 32'h10203040 + (32'h01010101 * i);
        build_model();
        load_block(1'b1);
        run_rounds(1'b0, 1'b0, 1'b0, -1);

        set_abc();
        load_block(1'b0);
        run_rounds(1'b0, 1'b0, 1'b1, 30);
        load_block(1'b0);
        run_rounds(1'b0, 1'b0, 1'b1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
